// File: rtl/fetch_pkg.sv
// Types and helpers shared by the fetch sequencer and its prefetch FIFO.
package fetch_pkg;

  import memory_pkg::*;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Misaligned or beyond the end of instruction memory; keeps the memory's
  // address aliasing from ever reaching decode.
  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr >= INSTR_MEM_SIZE_BYTES);
  endfunction

endpackage : fetch_pkg

// File: rtl/memory_pkg.sv
// Shared instruction-memory geometry.
package memory_pkg;

  localparam logic [31:0] INSTR_MEM_SIZE_BYTES = 32'h0000_0400;

endpackage : memory_pkg

// File: rtl/instr_fetch_ctrl_if.sv
// Instruction-memory read port plus decode valid/ready handshake.
interface instr_fetch_ctrl_if;

  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;

  modport master (
    output mem_addr_o,
    input  mem_data_i,
    output instr_valid_o,
    input  instr_ready_i,
    output instr_o,
    output instr_pc_o
  );

  modport slave (
    input  mem_addr_o,
    output mem_data_i,
    input  instr_valid_o,
    output instr_ready_i,
    input  instr_o,
    input  instr_pc_o
  );

endinterface : instr_fetch_ctrl_if

// File: rtl/instr_fetch_ctrl_fifo.sv
// Prefetch FIFO holding {pc, instr} entries; flush wins over push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  FIFO_DEPTH = 2,
  parameter type entry_t    = fetch_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  output logic   full,
  output logic   empty,
  input  entry_t din,
  output entry_t dout
);

  localparam int PtrW = $clog2(FIFO_DEPTH);
  localparam int CntW = PtrW + 1;

  entry_t            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt_q == CntW'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Storage is cleared on reset so the head reads as zero until first push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule : fetch_fifo

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the instruction-memory read port,
// prefetches into a small FIFO and traps bad fetch addresses.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       fetch_en_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_addr_i,
  output logic                       fault_o,
  output logic [31:0]                fault_addr_o,
  instr_fetch_ctrl_if.master         bus
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic         fault_q;
  logic [31:0]  fault_addr_q;

  fetch_entry_t fifo_din;
  fetch_entry_t fifo_dout;
  logic         fifo_full;
  logic         fifo_empty;
  logic         pop;
  logic         push;
  logic         push_req;
  logic         flush;
  logic         redirect_take;
  logic         redirect_bad;
  logic         pc_bad;
  logic         fault_event;

  assign pc_d = pc_q + 32'd4;

  // The FIFO stays empty in FAULT, so pop needs no state qualifier.
  assign pop           = !fifo_empty && bus.instr_ready_i;
  assign redirect_take = redirect_i && (state_q != FAULT);
  assign redirect_bad  = redirect_take && addr_bad(redirect_addr_i);
  assign push_req      = (state_q == RUN) && fetch_en_i && !redirect_i
                         && (!fifo_full || pop);
  assign pc_bad        = push_req && addr_bad(pc_q);
  assign fault_event   = redirect_bad || pc_bad;
  assign push          = push_req && !pc_bad;
  assign flush         = redirect_take || pc_bad;

  assign fifo_din.pc    = pc_q;
  assign fifo_din.instr = bus.mem_data_i;

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .entry_t    (fetch_entry_t)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .din    (fifo_din),
    .dout   (fifo_dout)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      pc_q         <= RESET_ADDR;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else if (fault_event) begin
      state_q      <= FAULT;
      fault_q      <= 1'b1;
      fault_addr_q <= redirect_bad ? redirect_addr_i : pc_q;
    end else begin
      if (redirect_take) begin
        pc_q <= redirect_addr_i;
      end else if (push) begin
        pc_q <= pc_d;
      end
      case (state_q)
        IDLE:    if (fetch_en_i)  state_q <= RUN;
        RUN:     if (!fetch_en_i) state_q <= IDLE;
        FAULT:   state_q <= FAULT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr_o    = pc_q;
  assign bus.instr_valid_o = !fifo_empty;
  assign bus.instr_o       = fifo_dout.instr;
  assign bus.instr_pc_o    = fifo_dout.pc;
  assign fault_o           = fault_q;
  assign fault_addr_o      = fault_addr_q;

endmodule : instr_fetch_ctrl

// File: tb/tb_instr_fetch_ctrl.sv
// Directed self-checking bench for instr_fetch_ctrl with a combinational
// instruction memory returning addr ^ 32'hA5A5_0000.
module tb_instr_fetch_ctrl;

  import memory_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        fault;
  logic [31:0] fault_addr;

  int total = 0;
  int bad   = 0;

  instr_fetch_ctrl_if bus ();

  assign bus.mem_data_i = bus.mem_addr_o ^ 32'hA5A5_0000;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(
    .RESET_ADDR (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .fetch_en_i      (fetch_en),
    .redirect_i      (redirect),
    .redirect_addr_i (redirect_addr),
    .fault_o         (fault),
    .fault_addr_o    (fault_addr),
    .bus             (bus.master)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_mem_addr"},   bus.mem_addr_o,           32'h0);
    check_eq({pfx, "_valid"},      {31'b0, bus.instr_valid_o}, 32'h0);
    check_eq({pfx, "_instr"},      bus.instr_o,              32'h0);
    check_eq({pfx, "_instr_pc"},   bus.instr_pc_o,           32'h0);
    check_eq({pfx, "_fault"},      {31'b0, fault},           32'h0);
    check_eq({pfx, "_fault_addr"}, fault_addr,               32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n             = 1'b0;
    fetch_en          = 1'b0;
    redirect          = 1'b0;
    redirect_addr     = 32'h0;
    bus.instr_ready_i = 1'b0;
    step();
    step();
    check_reset_vals("rst");

    // Stream: enable in cycle 0, first valid in cycle 2, then one per cycle.
    rst_n             = 1'b1;
    fetch_en          = 1'b1;
    bus.instr_ready_i = 1'b1;
    step();
    check_eq("lat_c1_valid", {31'b0, bus.instr_valid_o}, 32'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      check_eq("stream_valid", {31'b0, bus.instr_valid_o}, 32'h1);
      check_eq("stream_pc",    bus.instr_pc_o, 32'(4 * i));
      check_eq("stream_instr", bus.instr_o,    word(32'(4 * i)));
      step();
    end

    // Backpressure from a freshly restarted stream at 0x0.
    redirect          = 1'b1;
    redirect_addr     = 32'h0;
    bus.instr_ready_i = 1'b0;
    step();
    redirect = 1'b0;
    check_eq("bp_flush_valid", {31'b0, bus.instr_valid_o}, 32'h0);
    check_eq("bp_flush_addr",  bus.mem_addr_o, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_hold_pc", bus.instr_pc_o, 32'h0);
    end
    check_eq("bp_mem_addr", bus.mem_addr_o, 32'h8);
    check_eq("bp_valid",    {31'b0, bus.instr_valid_o}, 32'h1);
    check_eq("bp_instr",    bus.instr_o, word(32'h0));
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_rel_pc",    bus.instr_pc_o, 32'(4 * i));
      check_eq("bp_rel_instr", bus.instr_o,    word(32'(4 * i)));
      step();
    end

    // Redirect while holding two entries.
    bus.instr_ready_i = 1'b0;
    step();
    check_eq("full_pc",    bus.instr_pc_o, 32'h10);
    check_eq("full_addr",  bus.mem_addr_o, 32'h18);
    redirect      = 1'b1;
    redirect_addr = 32'h40;
    step();
    redirect = 1'b0;
    check_eq("redir_valid", {31'b0, bus.instr_valid_o}, 32'h0);
    check_eq("redir_addr",  bus.mem_addr_o, 32'h40);
    step();
    check_eq("redir_new_valid", {31'b0, bus.instr_valid_o}, 32'h1);
    check_eq("redir_new_pc",    bus.instr_pc_o, 32'h40);
    check_eq("redir_new_instr", bus.instr_o,    word(32'h40));

    // Redirect coincident with a pop of the 0x40 head.
    bus.instr_ready_i = 1'b1;
    redirect          = 1'b1;
    redirect_addr     = 32'h80;
    step();
    redirect = 1'b0;
    check_eq("rpop_valid", {31'b0, bus.instr_valid_o}, 32'h0);
    check_eq("rpop_addr",  bus.mem_addr_o, 32'h80);
    step();
    check_eq("rpop_new_pc", bus.instr_pc_o, 32'h80);
    step();
    check_eq("rpop_next_pc", bus.instr_pc_o, 32'h84);

    // Asynchronous reset between edges with a full FIFO.
    bus.instr_ready_i = 1'b0;
    step();
    check_eq("ar_full_valid", {31'b0, bus.instr_valid_o}, 32'h1);
    check_eq("ar_full_addr",  bus.mem_addr_o, 32'h8C);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    step();
    rst_n             = 1'b1;
    fetch_en          = 1'b1;
    bus.instr_ready_i = 1'b1;
    step();
    check_eq("ar_c1_valid", {31'b0, bus.instr_valid_o}, 32'h0);
    step();
    check_eq("ar_restart_valid", {31'b0, bus.instr_valid_o}, 32'h1);
    check_eq("ar_restart_pc",    bus.instr_pc_o, 32'h0);
    check_eq("ar_restart_instr", bus.instr_o,    word(32'h0));

    // Misaligned redirect traps; later redirects are ignored.
    redirect      = 1'b1;
    redirect_addr = 32'h42;
    step();
    redirect = 1'b0;
    check_eq("mis_fault",      {31'b0, fault}, 32'h1);
    check_eq("mis_fault_addr", fault_addr, 32'h42);
    check_eq("mis_valid",      {31'b0, bus.instr_valid_o}, 32'h0);
    redirect      = 1'b1;
    redirect_addr = 32'h0;
    step();
    redirect = 1'b0;
    step();
    check_eq("mis_ign_fault",      {31'b0, fault}, 32'h1);
    check_eq("mis_ign_fault_addr", fault_addr, 32'h42);
    check_eq("mis_ign_valid",      {31'b0, bus.instr_valid_o}, 32'h0);
    check_eq("mis_ign_addr_zero",  {31'b0, (bus.mem_addr_o == 32'h0)}, 32'h0);

    // Range boundary: last word delivered, then fault at the memory size.
    rst_n = 1'b0;
    step();
    rst_n         = 1'b1;
    fetch_en      = 1'b1;
    redirect      = 1'b1;
    redirect_addr = INSTR_MEM_SIZE_BYTES - 32'd4;
    step();
    redirect = 1'b0;
    check_eq("rng_addr",  bus.mem_addr_o, INSTR_MEM_SIZE_BYTES - 32'd4);
    check_eq("rng_valid0", {31'b0, bus.instr_valid_o}, 32'h0);
    step();
    check_eq("rng_last_valid", {31'b0, bus.instr_valid_o}, 32'h1);
    check_eq("rng_last_pc",    bus.instr_pc_o, INSTR_MEM_SIZE_BYTES - 32'd4);
    check_eq("rng_last_instr", bus.instr_o,    word(INSTR_MEM_SIZE_BYTES - 32'd4));
    check_eq("rng_nofault",    {31'b0, fault}, 32'h0);
    step();
    check_eq("rng_fault",      {31'b0, fault}, 32'h1);
    check_eq("rng_fault_addr", fault_addr, INSTR_MEM_SIZE_BYTES);
    check_eq("rng_valid",      {31'b0, bus.instr_valid_o}, 32'h0);
    step();
    check_eq("rng_no_alias",   {31'b0, bus.instr_valid_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_instr_fetch_ctrl
